ip_header_checker: RTL
======================

Name: ip_header_checker

Overview:
Receive-side counterpart of the IPv4 header checksum generator.
- Accepts an IPv4 packet as a 32-bit AXI-Stream: header words first, then payload, with tlast on the final beat.
- Parses the header (IHL 5..15), verifies the RFC 1071 checksum and sanity fields, and emits one header descriptor per packet over a valid/ready handshake.
- Forwards the payload of good packets unchanged to the UDP receive path. Drops the payload of bad packets.

Parameters:
DATA_W, 32, stream width; only 32 is supported.
CHECK_CSUM, 1, 1 = checksum mismatch sets the error bit; 0 = the checksum is not checked.

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous assert, active-low
s_axis_tdata  in  32  packet word, big-endian; word0[31:28] = version
s_axis_tvalid  in  1  input beat valid
s_axis_tready  out  1  input beat accepted
s_axis_tlast  in  1  last beat of packet
m_axis_tdata  out  32  payload word
m_axis_tvalid  out  1  payload beat valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  last payload beat
hdr_valid  out  1  descriptor valid
hdr_ready  in  1  descriptor accepted
hdr_src_ip  out  32  source address (word3)
hdr_dst_ip  out  32  destination address (word4)
hdr_protocol  out  8  word2[23:16]
hdr_total_len  out  16  word0[15:0]
hdr_ihl  out  4  word0[27:24]
hdr_err  out  5  error flags (see Behaviour)
hdr_ok  out  1  high when hdr_err == 0

Behaviour:
- Reset: async entry on reset_n low. State = HDR; word count, accumulator and all descriptor registers = 0. All outputs = 0, including s_axis_tready.
- States: HDR, DESC, PAYLOAD, DROP.
- HDR:
  - s_axis_tready = 1; each accepted beat increments word_cnt (4 bits).
  - Word0: capture version, ihl, total_len.
  - Word2: capture protocol. Word3: capture src. Word4: capture dst.
  - Every header beat adds data[31:16] + data[15:0] into a 32-bit accumulator. The maximum sum for 15 words is < 2^21, so it cannot overflow.
  - Header ends on the beat where word_cnt == max(ihl,5) - 1, or on an earlier tlast.
  - On header end go to DESC, and record last_seen = tlast of that beat.
- Checksum fold:
  - s17 = acc[31:16] + acc[15:0].
  - f = s17[15:0] + s17[16], with a 16-bit result.
  - Checksum is good iff f == 16'hFFFF.
- hdr_err bits, evaluated at DESC entry:
  - [0] version != 4
  - [1] ihl < 5
  - [2] checksum bad (only when CHECK_CSUM = 1)
  - [3] truncated: tlast before the header end
  - [4] total_len < 4*ihl
- DESC:
  - s_axis_tready = 0; hdr_valid = 1.
  - All hdr_* outputs hold stable until hdr_ready.
  - On hdr_valid && hdr_ready:
    - last_seen = 1: go to HDR.
    - Else hdr_ok = 1: go to PAYLOAD.
    - Else: go to DROP.
  - hdr_valid rises the cycle after the final header beat is accepted.
- PAYLOAD:
  - Zero-latency combinational passthrough: m_axis_tdata/tvalid/tlast = s_axis_*, and s_axis_tready = m_axis_tready.
  - Beat with tvalid && tready && tlast: go to HDR.
- DROP: s_axis_tready = 1, beats discarded, m_axis_tvalid = 0. Accepted tlast: go to HDR.
- On every return to HDR: clear word_cnt and the accumulator. A back-to-back packet can start the next cycle.
- Header-only packet (tlast on the final header word) is not an error. It produces a descriptor and no payload.
- Payload beat count is not checked against total_len. The checker forwards exactly what arrives, up to tlast.
- Reset mid-packet:
  - The partial packet is abandoned with no descriptor and no tlast downstream.
  - The first beat after reset release is parsed as word0.

Decomposition:
- Package ip_pkg:
  - IPV4_VERSION = 4, MIN_IHL = 5.
  - Error bit indices ERR_VER, ERR_IHL, ERR_CSUM, ERR_TRUNC, ERR_LEN, and ERR_W = 5.
  - Protocol constants PROTO_UDP = 8'h11, PROTO_TCP = 8'h06.
- One sub-module, ip_csum_verify: clear/accumulate inputs, 32-bit accumulator, fold logic, and a csum_good output. It is reusable by the UDP checksum path.

Test Plan:
1. Send header 45000073 00004000 4011B861 C0A80001 C0A800C7, then payload 11111111 22222222 33333333 (tlast on the third) -> descriptor with src C0A80001, dst C0A800C7, proto 11, total_len 0073, ihl 5, err 0, ok 1. The three payload words appear on m_axis with tlast on 33333333.
2. Same packet with word2 = 4011B862 -> err = 5'b00100, ok 0. m_axis_tvalid never high; s_axis_tready stays 1 through tlast; a following good packet parses correctly.
3. tlast on word1 (00004000) -> err[3] set, descriptor emitted, state returns to HDR with no DROP phase.
4. IHL = 6 header with options word 01010101 and the checksum recomputed by the bench model -> err 0. The six header words are consumed and payload starts at beat 6.
5. Hold hdr_ready low for 10 cycles in DESC -> s_axis_tready = 0 and descriptor fields stable. Toggle m_axis_tready randomly in PAYLOAD -> output beats match the input 1:1 with no loss or duplication.
6. Pull reset_n low mid-payload -> all outputs 0 in the same cycle, asynchronously. After release, the packet from scenario 1 parses with err 0.

Source files
------------

// File: rtl/ip_pkg.sv
// Shared IPv4 receive-path constants, error-flag layout and the parser state encoding.
package ip_pkg;

   localparam logic [3:0] IPV4_VERSION = 4'd4;
   localparam logic [3:0] MIN_IHL      = 4'd5;

   localparam int ERR_W     = 5;
   localparam int ERR_VER   = 0;
   localparam int ERR_IHL   = 1;
   localparam int ERR_CSUM  = 2;
   localparam int ERR_TRUNC = 3;
   localparam int ERR_LEN   = 4;

   localparam logic [7:0] PROTO_UDP = 8'h11;
   localparam logic [7:0] PROTO_TCP = 8'h06;

   typedef enum logic [1:0] {
      ST_HDR     = 2'd0,
      ST_DESC    = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_DROP    = 2'd3
   } rx_state_e;

   // Index of the last header word; an illegal IHL still consumes a minimum-size header.
   function automatic logic [3:0] hdr_last_idx(input logic [3:0] ihl);
      logic [3:0] eff;
      eff = (ihl < MIN_IHL) ? MIN_IHL : ihl;
      return eff - 4'd1;
   endfunction

endpackage

// File: rtl/ip_csum_verify.sv
// RFC 1071 ones'-complement accumulator with end-of-header fold; o_csum_good already
// includes the word presented on the current cycle so the verdict is ready on the last beat.
module ip_csum_verify
   import ip_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_clear,
   input  logic        i_accum,
   input  logic [31:0] i_data,
   output logic [31:0] o_acc,
   output logic        o_csum_good
);

   logic [31:0] r_acc;
   logic [31:0] w_sum;
   logic [16:0] w_s17;
   logic [15:0] w_fold;

   always_comb begin
      w_sum = r_acc;
      if (i_accum) begin
         w_sum = r_acc + {16'd0, i_data[31:16]} + {16'd0, i_data[15:0]};
      end
   end

   // At most 15 words of two halves: sum < 2^21, so a single fold plus carry is exact.
   assign w_s17       = {1'b0, w_sum[31:16]} + {1'b0, w_sum[15:0]};
   assign w_fold      = w_s17[15:0] + {15'd0, w_s17[16]};
   assign o_csum_good = (w_fold == 16'hFFFF);
   assign o_acc       = r_acc;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_acc <= '0;
      end else if (i_clear) begin
         r_acc <= '0;
      end else begin
         r_acc <= w_sum;
      end
   end

endmodule

// File: rtl/ip_header_checker.sv
// IPv4 receive header checker: parses and verifies the header, emits one descriptor per
// packet, then passes the payload through (good packets) or swallows it (bad packets).
module ip_header_checker
   import ip_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter bit CHECK_CSUM = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   input  logic              s_axis_tlast,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              m_axis_tlast,
   output logic              hdr_valid,
   input  logic              hdr_ready,
   output logic [31:0]       hdr_src_ip,
   output logic [31:0]       hdr_dst_ip,
   output logic [7:0]        hdr_protocol,
   output logic [15:0]       hdr_total_len,
   output logic [3:0]        hdr_ihl,
   output logic [ERR_W-1:0]  hdr_err,
   output logic              hdr_ok
);

   rx_state_e        r_state;
   rx_state_e        w_state_nxt;
   logic             r_run;
   logic [3:0]       r_word_cnt;
   logic [3:0]       r_ver;
   logic [3:0]       r_ihl;
   logic [15:0]      r_total_len;
   logic [7:0]       r_proto;
   logic [31:0]      r_src;
   logic [31:0]      r_dst;
   logic [ERR_W-1:0] r_err;
   logic             r_ok;
   logic             r_last_seen;

   logic             w_hdr_beat;
   logic             w_first;
   logic [3:0]       w_ver;
   logic [3:0]       w_ihl;
   logic [15:0]      w_total_len;
   logic             w_at_end;
   logic             w_hdr_done;
   logic [ERR_W-1:0] w_err;
   logic             w_csum_good;
   logic [31:0]      w_acc_unused;

   logic              w_s_tready;
   logic              w_m_tvalid;
   logic              w_m_tlast;
   logic [DATA_W-1:0] w_m_tdata;

   // r_run keeps tready low while reset is asserted and for the first edge after release.
   assign w_hdr_beat = (r_state == ST_HDR) && r_run && s_axis_tvalid;
   assign w_first    = (r_word_cnt == 4'd0);

   // Word0 fields come straight off the bus so a packet ending on word0 is judged correctly.
   assign w_ver       = w_first ? s_axis_tdata[31:28] : r_ver;
   assign w_ihl       = w_first ? s_axis_tdata[27:24] : r_ihl;
   assign w_total_len = w_first ? s_axis_tdata[15:0]  : r_total_len;

   assign w_at_end   = (r_word_cnt == hdr_last_idx(w_ihl));
   assign w_hdr_done = w_hdr_beat && (w_at_end || s_axis_tlast);

   always_comb begin
      w_err            = '0;
      w_err[ERR_VER]   = (w_ver != IPV4_VERSION);
      w_err[ERR_IHL]   = (w_ihl < MIN_IHL);
      w_err[ERR_CSUM]  = CHECK_CSUM && !w_csum_good;
      w_err[ERR_TRUNC] = s_axis_tlast && !w_at_end;
      w_err[ERR_LEN]   = (w_total_len < {10'd0, w_ihl, 2'b00});
   end

   ip_csum_verify u_csum (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_clear     (w_hdr_done),
      .i_accum     (w_hdr_beat),
      .i_data      (s_axis_tdata[31:0]),
      .o_acc       (w_acc_unused),
      .o_csum_good (w_csum_good)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_HDR;
         r_run       <= 1'b0;
         r_word_cnt  <= '0;
         r_ver       <= '0;
         r_ihl       <= '0;
         r_total_len <= '0;
         r_proto     <= '0;
         r_src       <= '0;
         r_dst       <= '0;
         r_err       <= '0;
         r_ok        <= 1'b0;
         r_last_seen <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_run   <= 1'b1;
         if (w_hdr_beat) begin
            r_word_cnt <= w_hdr_done ? 4'd0 : r_word_cnt + 4'd1;
            // Fields a truncated header never reaches read back as zero, not stale values.
            if (w_first) begin
               r_ver       <= s_axis_tdata[31:28];
               r_ihl       <= s_axis_tdata[27:24];
               r_total_len <= s_axis_tdata[15:0];
               r_proto     <= '0;
               r_src       <= '0;
               r_dst       <= '0;
            end
            if (r_word_cnt == 4'd2) r_proto <= s_axis_tdata[23:16];
            if (r_word_cnt == 4'd3) r_src   <= s_axis_tdata[31:0];
            if (r_word_cnt == 4'd4) r_dst   <= s_axis_tdata[31:0];
         end
         if (w_hdr_done) begin
            r_err       <= w_err;
            r_ok        <= (w_err == '0);
            r_last_seen <= s_axis_tlast;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_s_tready  = 1'b0;
      w_m_tvalid  = 1'b0;
      w_m_tlast   = 1'b0;
      w_m_tdata   = '0;
      case (r_state)
         ST_HDR: begin
            w_s_tready = r_run;
            if (w_hdr_done) w_state_nxt = ST_DESC;
         end
         ST_DESC: begin
            if (hdr_ready) begin
               if (r_last_seen)  w_state_nxt = ST_HDR;
               else if (r_ok)    w_state_nxt = ST_PAYLOAD;
               else              w_state_nxt = ST_DROP;
            end
         end
         ST_PAYLOAD: begin
            w_s_tready = m_axis_tready;
            w_m_tvalid = s_axis_tvalid;
            w_m_tlast  = s_axis_tlast;
            w_m_tdata  = s_axis_tdata;
            if (s_axis_tvalid && m_axis_tready && s_axis_tlast) w_state_nxt = ST_HDR;
         end
         ST_DROP: begin
            w_s_tready = 1'b1;
            if (s_axis_tvalid && s_axis_tlast) w_state_nxt = ST_HDR;
         end
         default: w_state_nxt = ST_HDR;
      endcase
   end

   assign s_axis_tready = w_s_tready;
   assign m_axis_tvalid = w_m_tvalid;
   assign m_axis_tlast  = w_m_tlast;
   assign m_axis_tdata  = w_m_tdata;

   assign hdr_valid     = (r_state == ST_DESC);
   assign hdr_src_ip    = r_src;
   assign hdr_dst_ip    = r_dst;
   assign hdr_protocol  = r_proto;
   assign hdr_total_len = r_total_len;
   assign hdr_ihl       = r_ihl;
   assign hdr_err       = r_err;
   assign hdr_ok        = r_ok;

endmodule
